// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: the sequencer states,
// the datapath word width and where the opcode field sits in an instruction.
package fetch_stage_pkg;

  localparam int XLEN   = 32;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int OP_W   = OP_MSB - OP_LSB + 1;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(4);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory, absorbs stalls
// through a one-entry buffer and redirects on taken branches.
//
//   state | meaning
//   FETCH | request outstanding at PC, waiting for ack
//   HELD  | fetched word parked in the buffer while decode stalls, no request
//   DRAIN | branch arrived before ack; old request still in flight, reply dropped
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic            if_id_valid,
  output logic [OP_W-1:0] opcode
);

  fetch_state_t state_q, state_d;

  word_t pc_q, pc_d;
  word_t buf_instr_q, buf_instr_d;
  word_t buf_pc4_q, buf_pc4_d;
  word_t pend_q, pend_d;
  word_t ifid_instr_q, ifid_instr_d;
  word_t ifid_pc4_q, ifid_pc4_d;
  logic  ifid_valid_q, ifid_valid_d;
  word_t pc_next;

  assign pc_next = pc_inc(pc_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_instr_d  = buf_instr_q;
    buf_pc4_d    = buf_pc4_q;
    pend_d       = pend_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    if (branch_taken) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_d = branch_target;
          end else begin
            pend_d  = branch_target;
            state_d = DRAIN;
          end
        end
        HELD: begin
          pc_d    = branch_target;
          state_d = FETCH;
        end
        DRAIN: begin
          // The reply to the stale request may land in the same cycle.
          if (imem_ack) begin
            pc_d    = branch_target;
            state_d = FETCH;
          end else begin
            pend_d = branch_target;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      // Decode consumes IF/ID whenever it is not stalled; refill with a bubble
      // unless a new instruction is delivered this cycle.
      if (!stall) begin
        ifid_instr_d = NOP_INSTR;
        ifid_pc4_d   = '0;
        ifid_valid_d = 1'b0;
      end
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_d = pc_next;
            if (stall) begin
              buf_instr_d = imem_rdata;
              buf_pc4_d   = pc_next;
              state_d     = HELD;
            end else begin
              ifid_instr_d = imem_rdata;
              ifid_pc4_d   = pc_next;
              ifid_valid_d = 1'b1;
            end
          end
        end
        HELD: begin
          if (!stall) begin
            ifid_instr_d = buf_instr_q;
            ifid_pc4_d   = buf_pc4_q;
            ifid_valid_d = 1'b1;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc_d    = pend_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      buf_instr_q  <= '0;
      buf_pc4_q    <= '0;
      pend_q       <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc4_q    <= buf_pc4_d;
      pend_q       <= pend_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_req    = rst_n && (state_q != HELD);
  assign imem_addr   = pc_q;
  assign if_id_instr = ifid_instr_q;
  assign if_id_pc4   = ifid_pc4_q;
  assign if_id_valid = ifid_valid_q;
  assign opcode      = ifid_instr_q[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then random ack/stall/branch/reset
// traffic checked by a monitor against an instruction-stream model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;
  logic [5:0]  w_opcode;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .opcode(opcode)
  );

  // Second instance starting at the top of the address space, always acked.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_rdata(32'h0), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .if_id_instr(w_instr), .if_id_pc4(w_pc4), .if_id_valid(w_valid),
    .opcode(w_opcode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        br;
    logic        stl;
    logic        req;
    logic        ack;
    logic [31:0] tgt;
    logic [31:0] addr;
  } rec_t;

  rec_t q[$];
  int tests = 0;
  int fails = 0;
  int delivered = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Applies one cycle of stimulus shortly after a falling edge; the memory
  // reply follows the (possibly reset-gated) request of this cycle.
  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [31:0] t, input logic a);
    #1;
    rst_n = r; stall = s; branch_taken = b; branch_target = t;
    #1;
    imem_ack   = a & imem_req;
    imem_rdata = word_of(imem_addr);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: each record describes the stimulus applied at the preceding
  // rising edge. The model only tracks the address of the next instruction
  // that decode should see; everything else follows from the record.
  logic [31:0] prev_instr, prev_pc4;
  logic        prev_valid;
  logic [31:0] exp_pc = 32'h0;

  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("opcode_field", {26'h0, opcode}, {26'h0, if_id_instr[31:26]});
        if (r.rst || r.br) begin
          chk(r.rst ? "rst_valid" : "flush_valid", {31'h0, if_id_valid}, 32'h0);
          chk(r.rst ? "rst_instr" : "flush_instr", if_id_instr, 32'h0);
          chk(r.rst ? "rst_pc4"   : "flush_pc4",   if_id_pc4,   32'h0);
          exp_pc = r.rst ? 32'h0 : r.tgt;
        end else if (r.stl) begin
          chk("stall_instr", if_id_instr, prev_instr);
          chk("stall_pc4",   if_id_pc4,   prev_pc4);
          chk("stall_valid", {31'h0, if_id_valid}, {31'h0, prev_valid});
        end else if (if_id_valid) begin
          chk("stream_instr", if_id_instr, word_of(exp_pc));
          chk("stream_pc4",   if_id_pc4,   exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
        if (!r.rst && r.req && !r.ack) begin
          chk("addr_hold_req", {31'h0, imem_req}, 32'h1);
          chk("addr_hold", imem_addr, r.addr);
        end
      end
      prev_instr = if_id_instr;
      prev_pc4   = if_id_pc4;
      prev_valid = if_id_valid;
    end
  end

  initial begin
    logic r, s, b, a;
    logic [31:0] t;
    @(negedge clk);

    // Reset values.
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_req_w", {31'h0, w_req}, 32'h0);
    tick();
    chk("rst_valid0", {31'h0, if_id_valid}, 32'h0);
    chk("rst_instr0", if_id_instr, 32'h0);
    chk("rst_pc40", if_id_pc4, 32'h0);

    // Release with ack every cycle.
    drive(1, 0, 0, 0, 1);
    chk("rel_req", {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_addr_w", w_addr, 32'hFFFF_FFFC);
    tick();
    chk("seq_pc4_0", if_id_pc4, 32'h4);
    chk("seq_valid_0", {31'h0, if_id_valid}, 32'h1);
    chk("seq_instr_0", if_id_instr, word_of(32'h0));
    chk("seq_addr_1", imem_addr, 32'h4);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_valid", {31'h0, w_valid}, 32'h1);
    chk("wrap_instr", w_instr, 32'h0);
    chk("wrap_opcode", {26'h0, w_opcode}, 32'h0);
    for (int i = 1; i < 4; i++) begin
      drive(1, 0, 0, 0, 1); tick();
      chk("seq_pc4", if_id_pc4, 32'(4 * (i + 1)));
      chk("seq_addr", imem_addr, 32'(4 * (i + 1)));
    end
    chk("wrap_addr_2", w_addr, 32'hC);

    // Unacked request at 0x10 redirected to 0x40.
    drive(1, 0, 1, 32'h40, 0); tick();
    chk("drain_addr", imem_addr, 32'h10);
    chk("drain_valid", {31'h0, if_id_valid}, 32'h0);
    chk("drain_opcode", {26'h0, opcode}, 32'h0);
    drive(1, 0, 0, 0, 1);
    chk("drain_addr_ack", imem_addr, 32'h10);
    tick();
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
    drive(1, 0, 0, 0, 1); tick();
    chk("redir_instr", if_id_instr, word_of(32'h40));
    chk("redir_pc4", if_id_pc4, 32'h44);

    // Ack under a three-cycle stall.
    drive(1, 1, 0, 0, 1); tick();
    for (int i = 0; i < 2; i++) begin
      chk("held_req", {31'h0, imem_req}, 32'h0);
      chk("held_pc4", if_id_pc4, 32'h44);
      chk("held_instr", if_id_instr, word_of(32'h40));
      drive(1, 1, 0, 0, 0); tick();
    end
    chk("held_req_3", {31'h0, imem_req}, 32'h0);
    drive(1, 0, 0, 0, 0); tick();
    chk("unheld_instr", if_id_instr, word_of(32'h44));
    chk("unheld_pc4", if_id_pc4, 32'h48);
    chk("unheld_valid", {31'h0, if_id_valid}, 32'h1);
    chk("unheld_addr", imem_addr, 32'h48);
    chk("unheld_req", {31'h0, imem_req}, 32'h1);

    // Branch with stall and ack together.
    drive(1, 1, 1, 32'h80, 1); tick();
    chk("bsa_valid", {31'h0, if_id_valid}, 32'h0);
    chk("bsa_instr", if_id_instr, 32'h0);
    chk("bsa_pc4", if_id_pc4, 32'h0);
    chk("bsa_addr", imem_addr, 32'h80);
    drive(1, 0, 0, 0, 1); tick();
    chk("bsa_next_pc4", if_id_pc4, 32'h84);

    // Reset while HELD.
    drive(1, 1, 0, 0, 1); tick();
    chk("pre_rst_held", {31'h0, imem_req}, 32'h0);
    drive(0, 1, 0, 0, 0); tick();
    chk("hrst_req", {31'h0, imem_req}, 32'h0);
    chk("hrst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("hrst_pc4", if_id_pc4, 32'h0);
    drive(1, 0, 0, 0, 0);
    chk("hrst_rel_req", {31'h0, imem_req}, 32'h1);
    chk("hrst_rel_addr", imem_addr, 32'h0);
    tick();

    // Random traffic, starting from a fresh reset.
    for (int n = 0; n < 3000; n++) begin
      r = (n == 0) ? 1'b0 : ($urandom_range(0, 249) != 0);
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 99) < 8);
      a = ($urandom_range(0, 9) < 6);
      t = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      drive(r, s, b, t, a);
      q.push_back('{rst: !r, br: b, stl: s, req: imem_req, ack: imem_ack,
                    tgt: t, addr: imem_addr});
      tick();
    end
    drive(1, 0, 0, 0, 0);
    #2;
    chk("sb_empty", 32'(q.size()), 32'h0);
    chk("progress", 32'(delivered > 300), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
